// File: rtl/cu_pkg.sv
// Shared encodings, FSM states and instruction field positions for ctrl_unit_mc.
// Field layout (MSB..LSB): class[2], X1, X2, X3, offset[DATA_WIDTH], opcode[4].
package cu_pkg;

    typedef enum logic [1:0] {
        CLS_NOP   = 2'b00,
        CLS_STD   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } cu_class_e;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_MEM_ACCESS = 3'd3,
        ST_WRITE_BACK = 3'd4
    } cu_state_e;

    localparam logic [3:0] OPCODE_RESET = 4'b1111;
    localparam int         OPCODE_LSB   = 0;
    localparam int         OFFSET_LSB   = 4;

    function automatic int x3_lsb(input int data_width);
        return OFFSET_LSB + data_width;
    endfunction

    function automatic int x2_lsb(input int data_width, input int addr_bits);
        return x3_lsb(data_width) + addr_bits;
    endfunction

    function automatic int x1_lsb(input int data_width, input int addr_bits);
        return x3_lsb(data_width) + 2 * addr_bits;
    endfunction

    function automatic int class_lsb(input int data_width, input int addr_bits);
        return x3_lsb(data_width) + 3 * addr_bits;
    endfunction

    function automatic int instr_width(input int data_width, input int addr_bits);
        return class_lsb(data_width, addr_bits) + 2;
    endfunction

endpackage

// File: rtl/cu_regfile.sv
// Register file for ctrl_unit_mc: one write port, three combinational read ports.
// Optional debug read port when CU_DEBUG_PORT_EN is defined.
module cu_regfile #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int REG_COUNT     = 4,
    localparam int REG_ADDR_BITS = $clog2(REG_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [REG_ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [REG_ADDR_BITS-1:0] rd_addr_x1,
    input  logic [REG_ADDR_BITS-1:0] rd_addr_x2,
    input  logic [REG_ADDR_BITS-1:0] rd_addr_x3,
    output logic [DATA_WIDTH-1:0]    rd_data_x1,
    output logic [DATA_WIDTH-1:0]    rd_data_x2,
    output logic [DATA_WIDTH-1:0]    rd_data_x3
`ifdef CU_DEBUG_PORT_EN
    ,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data
`endif
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    // Reset loads each register with its own index (truncated to DATA_WIDTH).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_x1 = regs[rd_addr_x1];
    assign rd_data_x2 = regs[rd_addr_x2];
    assign rd_data_x3 = regs[rd_addr_x3];

`ifdef CU_DEBUG_PORT_EN
    assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXECUTE -> MEM_ACCESS -> WRITE_BACK.
// Optional debug register read port enabled by defining CU_DEBUG_PORT_EN.
module ctrl_unit_mc
    import cu_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int REG_COUNT     = 4,
    localparam int REG_ADDR_BITS = $clog2(REG_COUNT),
    localparam int INSTR_WIDTH   = instr_width(DATA_WIDTH, REG_ADDR_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic [DATA_WIDTH-1:0]    result,
    input  logic                     mem_ready,
    output logic [DATA_WIDTH-1:0]    operand1,
    output logic [DATA_WIDTH-1:0]    operand2,
    output logic [DATA_WIDTH-1:0]    offset,
    output logic [3:0]               opcode,
    output logic                     sel1,
    output logic                     sel3,
    output logic                     w_r,
    output logic                     retire
`ifdef CU_DEBUG_PORT_EN
    ,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data
`endif
);

    localparam int X1_LSB  = x1_lsb(DATA_WIDTH, REG_ADDR_BITS);
    localparam int X2_LSB  = x2_lsb(DATA_WIDTH, REG_ADDR_BITS);
    localparam int X3_LSB  = x3_lsb(DATA_WIDTH);
    localparam int CLS_LSB = class_lsb(DATA_WIDTH, REG_ADDR_BITS);

    cu_state_e state, state_nx;

    logic [INSTR_WIDTH-1:0]   instr_q;
    cu_class_e                cls;
    logic [REG_ADDR_BITS-1:0] x1, x2, x3;
    logic [DATA_WIDTH-1:0]    imm;
    logic [3:0]               op;
    logic                     accept;

    logic [DATA_WIDTH-1:0]    rd_x1, rd_x2, rd_x3;
    logic                     rf_we;

    logic [DATA_WIDTH-1:0]    operand1_nx, operand2_nx, offset_nx;
    logic [3:0]               opcode_nx;
    logic                     sel1_nx, sel3_nx, w_r_nx, retire_nx, instr_ready_nx;

    assign cls    = cu_class_e'(instr_q[CLS_LSB +: 2]);
    assign x1     = instr_q[X1_LSB +: REG_ADDR_BITS];
    assign x2     = instr_q[X2_LSB +: REG_ADDR_BITS];
    assign x3     = instr_q[X3_LSB +: REG_ADDR_BITS];
    assign imm    = instr_q[OFFSET_LSB +: DATA_WIDTH];
    assign op     = instr_q[OPCODE_LSB +: 4];
    assign accept = (state == ST_FETCH) && instr_valid && instr_ready;
    assign rf_we  = (state == ST_WRITE_BACK);

    cu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we         (rf_we),
        .wr_addr    (x1),
        .wr_data    (result),
        .rd_addr_x1 (x1),
        .rd_addr_x2 (x2),
        .rd_addr_x3 (x3),
        .rd_data_x1 (rd_x1),
        .rd_data_x2 (rd_x2),
        .rd_data_x3 (rd_x3)
`ifdef CU_DEBUG_PORT_EN
        ,
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
`endif
    );

    // State register plus the registered copies of every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FETCH;
            instr_q     <= '0;
            operand1    <= '0;
            operand2    <= '0;
            offset      <= '0;
            opcode      <= OPCODE_RESET;
            sel1        <= 1'b0;
            sel3        <= 1'b0;
            w_r         <= 1'b0;
            retire      <= 1'b0;
            instr_ready <= 1'b0;
        end else begin
            state       <= state_nx;
            operand1    <= operand1_nx;
            operand2    <= operand2_nx;
            offset      <= offset_nx;
            opcode      <= opcode_nx;
            sel1        <= sel1_nx;
            sel3        <= sel3_nx;
            w_r         <= w_r_nx;
            retire      <= retire_nx;
            instr_ready <= instr_ready_nx;
            if (accept) begin
                instr_q <= instr;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_FETCH:      if (accept) state_nx = ST_DECODE;
            ST_DECODE:     state_nx = (cls == CLS_NOP) ? ST_FETCH : ST_EXECUTE;
            ST_EXECUTE:    state_nx = (cls == CLS_STD) ? ST_WRITE_BACK : ST_MEM_ACCESS;
            ST_MEM_ACCESS: begin
                if (mem_ready) begin
                    state_nx = (cls == CLS_LOAD) ? ST_WRITE_BACK : ST_FETCH;
                end
            end
            ST_WRITE_BACK: state_nx = ST_FETCH;
            default:       state_nx = ST_FETCH;
        endcase
    end

    // Next values for the output registers; unlisted outputs hold.
    always_comb begin
        operand1_nx    = operand1;
        operand2_nx    = operand2;
        offset_nx      = offset;
        opcode_nx      = opcode;
        sel1_nx        = sel1;
        sel3_nx        = sel3;
        w_r_nx         = w_r;
        retire_nx      = 1'b0;
        instr_ready_nx = (state_nx == ST_FETCH);
        unique case (state)
            ST_FETCH: ;
            ST_DECODE: begin
                if (cls == CLS_NOP) begin
                    retire_nx = 1'b1;
                end else begin
                    operand1_nx = rd_x2;
                    operand2_nx = (cls == CLS_STD) ? rd_x3 : rd_x1;
                    offset_nx   = imm;
                    opcode_nx   = op;
                    sel1_nx     = (cls == CLS_STD);
                    sel3_nx     = (cls != CLS_STD);
                    w_r_nx      = 1'b0;
                end
            end
            // Raising w_r on entry to MEM_ACCESS keeps it high for every waiting cycle.
            ST_EXECUTE: begin
                if (cls == CLS_STORE) w_r_nx = 1'b1;
            end
            ST_MEM_ACCESS: begin
                if (mem_ready) begin
                    w_r_nx = 1'b0;
                    if (cls == CLS_STORE) retire_nx = 1'b1;
                end
            end
            ST_WRITE_BACK: retire_nx = 1'b1;
            default:       w_r_nx = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Self-checking bench for ctrl_unit_mc: directed and randomized instructions vs. a latency/register model.
module tb_ctrl_unit_mc;

    localparam int DW  = 8;
    localparam int RC  = 4;
    localparam int RA  = 2;
    localparam int IW  = 20;
    localparam int DW2 = 16;
    localparam int RA2 = 3;
    localparam int IW2 = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, instr_valid, instr_ready, mem_ready;
    logic [IW-1:0] instr;
    logic [DW-1:0] result, operand1, operand2, offset;
    logic [3:0]    opcode;
    logic          sel1, sel3, w_r, retire;
`ifdef CU_DEBUG_PORT_EN
    logic [RA-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
`endif

    logic           w_rst, w_valid, w_ready, w_mem_ready;
    logic [IW2-1:0] w_instr;
    logic [DW2-1:0] w_result, w_operand1, w_operand2, w_offset;
    logic [3:0]     w_opcode;
    logic           w_sel1, w_sel3, w_w_r, w_retire;
`ifdef CU_DEBUG_PORT_EN
    logic [RA2-1:0] w_dbg_addr;
    logic [DW2-1:0] w_dbg_data;
`endif

    ctrl_unit_mc dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .result(result), .mem_ready(mem_ready),
        .operand1(operand1), .operand2(operand2), .offset(offset), .opcode(opcode),
        .sel1(sel1), .sel3(sel3), .w_r(w_r), .retire(retire)
`ifdef CU_DEBUG_PORT_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
    );

    ctrl_unit_mc #(.DATA_WIDTH(DW2), .REG_COUNT(8)) dut_wide (
        .clk(clk), .rst(w_rst), .instr_valid(w_valid), .instr_ready(w_ready),
        .instr(w_instr), .result(w_result), .mem_ready(w_mem_ready),
        .operand1(w_operand1), .operand2(w_operand2), .offset(w_offset), .opcode(w_opcode),
        .sel1(w_sel1), .sel3(w_sel3), .w_r(w_w_r), .retire(w_retire)
`ifdef CU_DEBUG_PORT_EN
        , .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register contents and the values the held outputs should show.
    logic [DW-1:0] mreg [RC];
    logic [DW-1:0] e_op1, e_op2, e_off;
    logic [3:0]    e_opc;
    logic          e_sel1, e_sel3;

    task automatic model_reset();
        for (int i = 0; i < RC; i++) mreg[i] = DW'(i);
        e_op1 = '0; e_op2 = '0; e_off = '0; e_opc = 4'b1111; e_sel1 = 1'b0; e_sel3 = 1'b0;
    endtask

    // Issue one instruction at the current negedge and follow it to retire.
    task automatic run_instr(input logic [1:0] cls, input logic [RA-1:0] x1, input logic [RA-1:0] x2,
                             input logic [RA-1:0] x3, input logic [DW-1:0] off, input logic [3:0] opc,
                             input int waits, input logic [DW-1:0] res);
        int exp_lat, lat, wcnt;
        case (cls)
            2'b00:   exp_lat = 1;
            2'b01:   exp_lat = 3;
            2'b10:   exp_lat = 4 + waits;
            default: exp_lat = 3 + waits;
        endcase
        if (cls != 2'b00) begin
            e_op1 = mreg[x2]; e_op2 = (cls == 2'b01) ? mreg[x3] : mreg[x1];
            e_off = off; e_opc = opc; e_sel1 = (cls == 2'b01); e_sel3 = (cls != 2'b01);
        end
        total++;
        if (instr_ready !== 1'b1) begin
            bad++; $display("FAIL ready_before_issue: got %b want 1", instr_ready);
        end
        instr = {cls, x1, x2, x3, off, opc};
        instr_valid = 1'b1; mem_ready = 1'b0; result = res;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; instr = IW'($urandom);
        total++;
        if (retire !== 1'b0) begin
            bad++; $display("FAIL retire_early: got %b want 0", retire);
        end
        lat = 0; wcnt = 0;
        mem_ready = 1'($urandom_range(0, 1));
        for (int k = 1; k <= exp_lat + 8 && lat == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) begin
                total++;
                if ({operand1, operand2, offset, opcode, sel1, sel3, w_r} !==
                    {e_op1, e_op2, e_off, e_opc, e_sel1, e_sel3, 1'b0}) begin
                    bad++;
                    $display("FAIL decode_outputs cls=%0d: got op1=%h op2=%h off=%h opc=%h sel1=%b sel3=%b w_r=%b want op1=%h op2=%h off=%h opc=%h sel1=%b sel3=%b w_r=0",
                             cls, operand1, operand2, offset, opcode, sel1, sel3, w_r,
                             e_op1, e_op2, e_off, e_opc, e_sel1, e_sel3);
                end
            end
            if (w_r === 1'b1) wcnt++;
            if (retire === 1'b1) lat = k;
            if (cls[1] && k >= 2) mem_ready = (k == 2 + waits);
            else mem_ready = 1'($urandom_range(0, 1));
        end
        mem_ready = 1'b0;
        total++;
        if (lat != exp_lat) begin
            bad++; $display("FAIL latency cls=%0d waits=%0d: got %0d want %0d (0 = no retire)", cls, waits, lat, exp_lat);
        end
        total++;
        if (wcnt != ((cls == 2'b11) ? waits + 1 : 0)) begin
            bad++; $display("FAIL w_r_cycles cls=%0d: got %0d want %0d", cls, wcnt, (cls == 2'b11) ? waits + 1 : 0);
        end
        total++;
        if ({instr_ready, w_r} !== 2'b10) begin
            bad++; $display("FAIL retire_cycle ready/w_r: got %b%b want 10", instr_ready, w_r);
        end
        if (cls == 2'b01 || cls == 2'b10) mreg[x1] = res;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_rst = 1'b1;
        instr_valid = 1'b0; instr = '0; result = '0; mem_ready = 1'b0;
        w_valid = 1'b0; w_instr = '0; w_result = '0; w_mem_ready = 1'b0;
`ifdef CU_DEBUG_PORT_EN
        dbg_addr = '0; w_dbg_addr = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({operand1, operand2, offset} !== '0) begin
            bad++; $display("FAIL reset_operands: got %h %h %h want 0 0 0", operand1, operand2, offset);
        end
        total++;
        if (opcode !== 4'b1111) begin
            bad++; $display("FAIL reset_opcode: got %h want f", opcode);
        end
        total++;
        if ({sel1, sel3, w_r, retire, instr_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {sel1, sel3, w_r, retire, instr_ready});
        end
        total++;
        if ({w_operand1, w_operand2, w_offset, w_opcode, w_sel1, w_sel3, w_w_r, w_retire, w_ready} !==
            {48'h0, 4'hf, 5'b0}) begin
            bad++; $display("FAIL reset_wide: got op1=%h op2=%h off=%h opc=%h flags=%b", w_operand1, w_operand2,
                            w_offset, w_opcode, {w_sel1, w_sel3, w_w_r, w_retire, w_ready});
        end
        rst = 1'b0; w_rst = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({instr_ready, w_ready} !== 2'b11) begin
            bad++; $display("FAIL ready_after_reset: got %b want 11", {instr_ready, w_ready});
        end
    endtask

    task automatic test_std();
        run_instr(2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 4'h0, 0, 8'h03);
    endtask

    task automatic test_load();
        run_instr(2'b10, 2'd0, 2'd2, 2'd0, 8'h05, 4'h0, 2, 8'hAA);
    endtask

    task automatic test_store();
        run_instr(2'b11, 2'd1, 2'd3, 2'd0, 8'h00, 4'h0, 1, 8'h5A);
        run_instr(2'b11, 2'd0, 2'd3, 2'd1, 8'h07, 4'h9, 0, 8'h11);
    endtask

    task automatic test_back_to_back();
        run_instr(2'b01, 2'd1, 2'd2, 2'd3, 8'h00, 4'h1, 0, mreg[2] + mreg[3]);
        run_instr(2'b01, 2'd0, 2'd1, 2'd1, 8'h00, 4'h1, 0, mreg[1] + mreg[1]);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_instr(2'($urandom), RA'($urandom), RA'($urandom), RA'($urandom), DW'($urandom),
                      4'($urandom), $urandom_range(0, 3), DW'($urandom));
`ifdef CU_DEBUG_PORT_EN
            dbg_addr = RA'($urandom); #1;
            total++;
            if (dbg_data !== mreg[dbg_addr]) begin
                bad++; $display("FAIL dbg_read R%0d: got %h want %h", dbg_addr, dbg_data, mreg[dbg_addr]);
            end
`endif
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); @(negedge clk);
                    total++;
                    if ({retire, instr_ready} !== 2'b01) begin
                        bad++; $display("FAIL idle retire/ready: got %b want 01", {retire, instr_ready});
                    end
                end
                mem_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 2; c <= 3; c++) begin
            instr = {2'(c), 2'd1, 2'd2, 2'd0, 8'h10, 4'h3};
            instr_valid = 1'b1; mem_ready = 1'b0; result = DW'($urandom);
            @(posedge clk); @(negedge clk);
            instr_valid = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            total++;
            if (w_r !== (c == 3)) begin
                bad++; $display("FAIL mem_access_w_r cls=%0d: got %b want %b", c, w_r, c == 3);
            end
            @(posedge clk); #2 rst = 1'b1; #1;
            total++;
            if ({operand1, operand2, offset, opcode, sel1, sel3, w_r, retire, instr_ready} !==
                {24'h0, 4'hf, 5'b0}) begin
                bad++; $display("FAIL async_reset cls=%0d: got op1=%h op2=%h off=%h opc=%h flags=%b", c,
                                operand1, operand2, offset, opcode, {sel1, sel3, w_r, retire, instr_ready});
            end
            @(negedge clk); rst = 1'b0;
            model_reset();
            @(posedge clk); @(negedge clk);
            total++;
            if (instr_ready !== 1'b1) begin
                bad++; $display("FAIL ready_after_mid_reset: got %b want 1", instr_ready);
            end
            run_instr(2'b11, 2'd0, 2'd1, 2'd2, 8'h00, 4'h0, 0, 8'h00);
            run_instr(2'b11, 2'd2, 2'd3, 2'd0, 8'h00, 4'h0, 0, 8'h00);
        end
    endtask

    task automatic test_wide();
        logic [DW2-1:0] res;
        int lat;
        res = DW2'($urandom);
        w_result = res;
        w_instr = {2'b01, 3'd7, 3'd5, 3'd6, 16'h1234, 4'h2};
        total++;
        if (w_ready !== 1'b1) begin
            bad++; $display("FAIL wide_ready: got %b want 1", w_ready);
        end
        w_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        w_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) begin
                total++;
                if ({w_operand1, w_operand2, w_offset} !== {16'd5, 16'd6, 16'h1234}) begin
                    bad++; $display("FAIL wide_decode: got %h %h %h want 0005 0006 1234", w_operand1, w_operand2, w_offset);
                end
            end
            if (w_retire === 1'b1) lat = k;
        end
        total++;
        if (lat != 3) begin
            bad++; $display("FAIL wide_latency: got %0d want 3", lat);
        end
`ifdef CU_DEBUG_PORT_EN
        w_dbg_addr = 3'd7; #1;
        total++;
        if (w_dbg_data !== res) begin
            bad++; $display("FAIL wide_dbg_r7: got %h want %h", w_dbg_data, res);
        end
`endif
        w_instr = {2'b01, 3'd0, 3'd7, 3'd6, 16'h0, 4'h0};
        w_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        w_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if (w_operand1 !== res) begin
            bad++; $display("FAIL wide_r7_readback: got %h want %h", w_operand1, res);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_std();
        test_load();
        test_store();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
